// File: rtl/muldiv_if.sv
// Handshake and HI/LO bus between the control unit and the multiply/divide unit.
// The master is the controller, and the slave is the execute unit.
interface muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU execute unit holding the HI/LO registers.
// Latency is fixed at 34 cycles from the start edge to the done pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// RUN   | 32 iterations of shift-add / restoring shift-subtract
// FIX   | sign correction; result loaded into hi/lo at the exit edge
// DONE  | done pulse, busy low; a start here is accepted as in IDLE
module muldiv_unit #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] HI_RST = '0,
    parameter logic [WIDTH-1:0] LO_RST = '0
) (
    input logic     clock,
    input logic     reset,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic               accept;

    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   b_mag_q;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_sh;
    logic               div_ok;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == '1) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.busy = (state == S_RUN) || (state == S_FIX);
    assign bus.done = (state == S_DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Operand magnitudes at accept time; op[0]=0 selects the signed forms
    always_comb begin
        a_neg = ~bus.op[0] & bus.rs_data[WIDTH-1];
        b_neg = ~bus.op[0] & bus.rt_data[WIDTH-1];
        a_mag = a_neg ? -bus.rs_data : bus.rs_data;
        b_mag = b_neg ? -bus.rt_data : bus.rt_data;
    end

    // One multiply step and one restoring-divide step on the accumulator
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag_q} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ok   = (div_sh >= {1'b0, b_mag_q});
        div_diff = div_sh[WIDTH-1:0] - b_mag_q;
        if (div_ok) begin
            div_next = {div_diff, acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction of the final result
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];
    end

    // Operand latch and iteration datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            b_mag_q <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else if (accept) begin
            is_div  <= bus.op[1];
            // A zero divisor gives an all-ones quotient and the dividend
            // magnitude as remainder, so the quotient must not be negated.
            neg_q   <= (a_neg ^ b_neg) & ~(bus.op[1] & (bus.rt_data == '0));
            neg_r   <= a_neg;
            b_mag_q <= b_mag;
            acc     <= {{WIDTH{1'b0}}, a_mag};
            cnt     <= '0;
        end else if (state == S_RUN) begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + CW'(1);
        end
    end

    // HI/LO: result load on FIX exit, MTHI/MTLO only while idle
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q <= HI_RST;
            lo_q <= LO_RST;
        end else if (state == S_FIX) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else if (state == S_IDLE) begin
            if (bus.hi_we) begin
                hi_q <= bus.wdata;
            end
            if (bus.lo_we) begin
                lo_q <= bus.wdata;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a table of operations plus hand sequences
// for reset, back-to-back start, MTHI/MTLO and mid-operation reset.
module tb_muldiv_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(
        .WIDTH (32),
        .HI_RST(32'h0),
        .LO_RST(32'h0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        string       name;
    } vec_t;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    vec_t        vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
    endtask

    // Entered in cycle 1; returns in the done cycle (or after the budget).
    // With noise set, operands, op, start and MTHI/MTLO are scrambled while busy.
    task automatic run_to_done(input bit noise, output int cyc, output bit busy_ok,
                               output bit hold_ok);
        cyc     = 1;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.hi !== model_hi || bus.lo !== model_lo) hold_ok = 1'b0;
            if (noise) begin
                bus.start   = (cyc >= 2 && cyc <= 20);
                bus.op      = 2'(cyc);
                bus.rs_data = $urandom;
                bus.rt_data = $urandom;
                bus.hi_we   = 1'b1;
                bus.lo_we   = 1'b1;
                bus.wdata   = $urandom;
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int  cyc;
        bit  busy_ok, hold_ok, saw_done;

        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.hi_we   = 1'b1;
        bus.lo_we   = 1'b0;
        bus.wdata   = 32'h1234;
        reset       = 1'b1;

        vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
        vecs[1] = '{OP_MULT,  32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m7x3"};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2"};
        vecs[3] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_100d7"};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
        vecs[5] = '{OP_DIVU,  32'h00000055, 32'h00000000, 32'h00000055, 32'hFFFFFFFF, "divu_by0"};
        vecs[6] = '{OP_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, "div_neg_by0"};
        vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min_sq"};
        vecs[8] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7dm2"};
        vecs[9] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, "multu_x16"};

        // Reset overrides an MTHI write
        tick();
        tick();
        check("rst_hi",   64'(bus.hi),   64'h0);
        check("rst_lo",   64'(bus.lo),   64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_done", 64'(bus.done), 64'h0);
        reset     = 1'b0;
        bus.hi_we = 1'b0;
        tick();
        check("rst_hi_after", 64'(bus.hi), 64'h0);
        model_hi = '0;
        model_lo = '0;

        // Table: latency, busy window, HI/LO hold, result, ignored DONE write
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            bus.start = 1'b0;
            run_to_done(1'b1, cyc, busy_ok, hold_ok);
            check({vecs[i].name, "_latency"}, 64'(cyc), 64'd34);
            check({vecs[i].name, "_busy"},    64'(busy_ok), 64'd1);
            check({vecs[i].name, "_hold"},    64'(hold_ok), 64'd1);
            check({vecs[i].name, "_hi"},      64'(bus.hi), 64'(vecs[i].ehi));
            check({vecs[i].name, "_lo"},      64'(bus.lo), 64'(vecs[i].elo));
            check({vecs[i].name, "_busy_done"}, 64'(bus.busy), 64'd0);
            model_hi = vecs[i].ehi;
            model_lo = vecs[i].elo;
            tick();
            bus.hi_we = 1'b0;
            bus.lo_we = 1'b0;
            check({vecs[i].name, "_done_wr_hi"}, 64'(bus.hi), 64'(model_hi));
            check({vecs[i].name, "_done_wr_lo"}, 64'(bus.lo), 64'(model_lo));
            check({vecs[i].name, "_no_queue"},   64'({bus.busy, bus.done}), 64'd0);
        end

        // Back-to-back: new start accepted in the DONE cycle
        start_op(OP_MULT, 32'hFFFFFFF9, 32'h00000003);
        tick();
        bus.start = 1'b0;
        run_to_done(1'b0, cyc, busy_ok, hold_ok);
        check("b2b_first_lat", 64'(cyc), 64'd34);
        check("b2b_first_res", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);
        model_hi = 32'hFFFFFFFF;
        model_lo = 32'hFFFFFFEB;
        start_op(OP_MULT, 32'h80000000, 32'h00000002);
        tick();
        bus.start = 1'b0;
        check("b2b_accepted", 64'(bus.busy), 64'd1);
        run_to_done(1'b0, cyc, busy_ok, hold_ok);
        check("b2b_second_lat",  64'(cyc), 64'd34);
        check("b2b_second_busy", 64'(busy_ok), 64'd1);
        check("b2b_second_res",  {bus.hi, bus.lo}, 64'hFFFFFFFF_00000000);
        model_hi = 32'hFFFFFFFF;
        model_lo = 32'h00000000;
        tick();

        // Idle MTLO, then MTHI+MTLO together
        bus.lo_we = 1'b1;
        bus.wdata = 32'hCAFEF00D;
        tick();
        bus.lo_we = 1'b0;
        check("mtlo_lo", 64'(bus.lo), 64'hCAFEF00D);
        check("mtlo_hi", 64'(bus.hi), 64'(model_hi));
        model_lo  = 32'hCAFEF00D;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0BADCAFE;
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("mthilo_both", {bus.hi, bus.lo}, 64'h0BADCAFE_0BADCAFE);
        model_hi = 32'h0BADCAFE;
        model_lo = 32'h0BADCAFE;

        // MTHI in the start cycle lands, then the result overwrites it
        start_op(OP_DIVU, 32'd100, 32'd7);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h11112222;
        tick();
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        check("start_wr_hi", 64'(bus.hi), 64'h11112222);
        model_hi = 32'h11112222;
        run_to_done(1'b1, cyc, busy_ok, hold_ok);
        check("start_wr_lat",  64'(cyc), 64'd34);
        check("start_wr_hold", 64'(hold_ok), 64'd1);
        check("start_wr_res",  {bus.hi, bus.lo}, {32'd2, 32'd14});
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;

        // Reset in cycle 10 of a MULT discards it
        start_op(OP_MULT, 32'd5, 32'd6);
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        check("midrst_busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_hilo", {bus.hi, bus.lo}, 64'h0);
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            tick();
        end
        check("midrst_no_done", 64'(saw_done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide execute unit for the MIPS datapath.
- Sits directly downstream of the register file. It consumes the two register read ports (rs on ReadData1, rt on ReadData2) for MULT, MULTU, DIV and DIVU.
- Holds the architectural HI/LO registers, which feed MFHI/MFLO back to the write-back path.
- Multi-cycle, with a start/busy/done handshake so the control unit can stall on HI/LO hazards.

Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is required to be supported.
- HI_RST, 0, reset value of HI.
- LO_RST, 0, reset value of LO.

Ports:
- clock  input  1  single clock, rising-edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
- start  input  1  request a new operation; sampled only when busy=0.
- op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- rs_data  input  32  multiplicand or dividend (from ReadData1).
- rt_data  input  32  multiplier or divisor (from ReadData2).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  32  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result in this same cycle.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset, checked at every rising edge when reset=1:
  - state=IDLE, busy=0, done=0, hi=HI_RST, lo=LO_RST.
  - Any operation in flight is discarded. Reset overrides start, hi_we and lo_we.
- FSM states are IDLE, RUN, FIX and DONE. Cycle numbering: cycle 0 is the cycle in which start=1 is sampled with busy=0.
  - IDLE: start=1 latches op and both operands, clears the iteration counter, and moves to RUN. busy=1 from cycle 1.
  - RUN, cycles 1..32: one iteration per cycle.
    - Multiply: shift-add on a 64-bit accumulator.
    - Divide: restoring shift-subtract, giving 1 quotient bit per cycle.
    - A 5-bit counter wraps 31->0 on the transition to FIX.
  - FIX, cycle 33: apply the sign correction and compute the final 64-bit result.
  - DONE, cycle 34:
    - hi/lo are loaded at the edge entering DONE.
    - done=1 and busy=0 in this cycle.
    - The next state is IDLE, unless start=1 is sampled in DONE; that start is accepted exactly as in IDLE.
- Fixed latency: done asserts exactly 34 cycles after the start-sampling edge, for every op and all operand values.
- start while busy=1 is ignored, not queued.
- Signed operations (MULT, DIV):
  - Operands are converted to magnitudes in cycle 0 latch. 0x80000000 has magnitude 2^31, handled as an unsigned 33-bit value.
  - MULT: the 64-bit product is negated if the operand signs differ. {hi,lo} = full 64-bit product.
  - DIV: lo = quotient, truncated toward zero. hi = remainder, with the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0x00000000.
- Unsigned operations (MULTU, DIVU): no sign handling.
- Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=rs_data as latched. Same 34-cycle latency, no exception.
- MTHI/MTLO:
  - When busy=0, hi_we/lo_we load wdata into hi/lo at the next edge. Both may be asserted together.
  - If start is asserted in the same cycle, the write still happens; the operation result overwrites it in DONE.
  - hi_we/lo_we while busy=1 are ignored.
  - A write in the DONE cycle is ignored, because the result load has priority.
- Operand inputs are don't-care after cycle 0; changes to them must not affect the result.
- Outputs hi/lo change only on reset, the DONE load, or an idle MTHI/MTLO write.

Test Plan:
- Reset: assert reset for 2 cycles with hi_we=1, wdata=0x1234 -> hi=0, lo=0, busy=0, done=0; hi still 0 after release.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done in cycle 34, hi=0xFFFFFFFE, lo=0x00000001.
  - busy high for cycles 1..33; start pulses during busy ignored.
- MULT -7 x 3 -> {hi,lo} = 0xFFFFFFFF_FFFFFFEB.
  - Back-to-back: start in the DONE cycle with MULT 0x80000000 x 2 -> hi=0xFFFFFFFF, lo=0x00000000 at 34 cycles later.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 100 / 7 -> lo=14, hi=2.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x55 / 0 -> lo=0xFFFFFFFF, hi=0x00000055 at cycle 34.
  - Operands changed on cycle 1 have no effect.
- MTHI/MTLO and mid-operation reset:
  - Idle lo_we with wdata=0xCAFEF00D -> lo updated next cycle.
  - hi_we during RUN -> hi unchanged.
  - reset in cycle 10 of a MULT -> busy=0, hi=lo=0, and no done pulse follows.
